// File: rtl/bus_fabric.sv
// Slave-bus datapath behind the two-master arbiter: master mux, address decode,
// registered read return and decode-error pulse.
module bus_fabric #(
    parameter int            AW      = 8,
    parameter int            DW      = 32,
    parameter logic [AW-1:0] S0_BASE = AW'(8'h00),
    parameter logic [AW-1:0] S1_BASE = AW'(8'h20),
    parameter logic [AW-1:0] S_MASK  = AW'(8'hE0)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          M0_grant,
    input  logic          M1_grant,
    input  logic [AW-1:0] M0_address,
    input  logic          M0_wr,
    input  logic [DW-1:0] M0_dout,
    input  logic [AW-1:0] M1_address,
    input  logic          M1_wr,
    input  logic [DW-1:0] M1_dout,
    input  logic [DW-1:0] S0_dout,
    input  logic [DW-1:0] S1_dout,
    output logic [AW-1:0] S_address,
    output logic          S_wr,
    output logic [DW-1:0] S_din,
    output logic          S0_sel,
    output logic          S1_sel,
    output logic [DW-1:0] M_din,
    output logic          M_din_valid,
    output logic          bus_err
);

    logic       w_grantActive;
    logic       w_hit0;
    logic       w_hit1;
    logic [1:0] r_rdSel;
    logic       r_busErr;

    assign w_grantActive = M0_grant | M1_grant;

    // M0 wins a double grant; with no grant the bus is parked at zero.
    always_comb begin
        S_address = '0;
        S_wr      = 1'b0;
        S_din     = '0;
        if (M0_grant) begin
            S_address = M0_address;
            S_wr      = M0_wr;
            S_din     = M0_dout;
        end else if (M1_grant) begin
            S_address = M1_address;
            S_wr      = M1_wr;
            S_din     = M1_dout;
        end
    end

    assign w_hit0 = w_grantActive && ((S_address & S_MASK) == S0_BASE);
    assign w_hit1 = w_grantActive && ((S_address & S_MASK) == S1_BASE) && !w_hit0;
    assign S0_sel = w_hit0;
    assign S1_sel = w_hit1;

    // The read owner is captured here so a grant change after issue cannot redirect returned data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdSel  <= 2'b00;
            r_busErr <= 1'b0;
        end else begin
            r_rdSel  <= {w_hit1 & ~S_wr, w_hit0 & ~S_wr};
            r_busErr <= w_grantActive & ~w_hit0 & ~w_hit1;
        end
    end

    always_comb begin
        M_din = '0;
        case (r_rdSel)
            2'b01:   M_din = S0_dout;
            2'b10:   M_din = S1_dout;
            default: M_din = '0;
        endcase
    end

    assign M_din_valid = |r_rdSel;
    assign bus_err     = r_busErr;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed plus randomized bench for bus_fabric, checked against a region-based
// reference model of the slave map and one-cycle read return.
module tb_bus_fabric;

    logic        clk;
    logic        reset_n;
    logic        M0_grant, M1_grant;
    logic [7:0]  M0_address, M1_address;
    logic        M0_wr, M1_wr;
    logic [31:0] M0_dout, M1_dout;
    logic [31:0] S0_dout, S1_dout;
    logic [7:0]  S_address;
    logic        S_wr;
    logic [31:0] S_din;
    logic        S0_sel, S1_sel;
    logic [31:0] M_din;
    logic        M_din_valid;
    logic        bus_err;

    int compCount = 0;
    int errCount  = 0;

    // Model state: which slave (0 = none, 1 = S0, 2 = S1) owes data this cycle.
    int mdlPending  = 0;
    bit mdlErr      = 0;
    int nextPending = 0;
    bit nextErr     = 0;

    bus_fabric dut (
        .clk(clk), .reset_n(reset_n),
        .M0_grant(M0_grant), .M1_grant(M1_grant),
        .M0_address(M0_address), .M0_wr(M0_wr), .M0_dout(M0_dout),
        .M1_address(M1_address), .M1_wr(M1_wr), .M1_dout(M1_dout),
        .S0_dout(S0_dout), .S1_dout(S1_dout),
        .S_address(S_address), .S_wr(S_wr), .S_din(S_din),
        .S0_sel(S0_sel), .S1_sel(S1_sel),
        .M_din(M_din), .M_din_valid(M_din_valid), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit g0, input bit g1,
                                 input logic [7:0] a0, input bit w0, input logic [31:0] d0,
                                 input logic [7:0] a1, input bit w1, input logic [31:0] d1,
                                 input logic [31:0] s0d, input logic [31:0] s1d);
        M0_grant = g0;  M1_grant = g1;
        M0_address = a0; M0_wr = w0; M0_dout = d0;
        M1_address = a1; M1_wr = w1; M1_dout = d1;
        S0_dout = s0d;  S1_dout = s1d;
    endtask

    // Expected values come from the slave map: each slave owns one 32-address region.
    task automatic checkOutput(input string tag);
        bit          active;
        logic [7:0]  eAddr;
        bit          eWr;
        logic [31:0] eDin;
        int          region;
        bit          eSel0, eSel1;
        logic [31:0] eMdin;
        active = M0_grant || M1_grant;
        eAddr = 8'h00; eWr = 1'b0; eDin = 32'h0;
        if (M0_grant) begin
            eAddr = M0_address; eWr = M0_wr; eDin = M0_dout;
        end else if (M1_grant) begin
            eAddr = M1_address; eWr = M1_wr; eDin = M1_dout;
        end
        region = int'(eAddr) / 32;
        eSel0 = active && (region == 0);
        eSel1 = active && (region == 1);
        eMdin = (mdlPending == 1) ? S0_dout : (mdlPending == 2) ? S1_dout : 32'h0;

        checkVal({tag, ".S_address"}, {24'h0, S_address}, {24'h0, eAddr});
        checkVal({tag, ".S_wr"}, {31'h0, S_wr}, {31'h0, eWr});
        checkVal({tag, ".S_din"}, S_din, eDin);
        checkVal({tag, ".S0_sel"}, {31'h0, S0_sel}, {31'h0, eSel0});
        checkVal({tag, ".S1_sel"}, {31'h0, S1_sel}, {31'h0, eSel1});
        checkVal({tag, ".M_din"}, M_din, eMdin);
        checkVal({tag, ".M_din_valid"}, {31'h0, M_din_valid}, {31'h0, (mdlPending != 0)});
        checkVal({tag, ".bus_err"}, {31'h0, bus_err}, {31'h0, mdlErr});

        nextPending = (eWr) ? 0 : (eSel0 ? 1 : (eSel1 ? 2 : 0));
        nextErr     = active && !eSel0 && !eSel1;
    endtask

    task automatic stepCycle(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        if (reset_n) begin
            mdlPending = nextPending;
            mdlErr     = nextErr;
        end else begin
            mdlPending = 0;
            mdlErr     = 1'b0;
        end
        #1;
    endtask

    task automatic assertReset();
        reset_n    = 1'b0;
        mdlPending = 0;
        mdlErr     = 1'b0;
    endtask

    initial begin
        logic [7:0]  ra0, ra1;
        logic [31:0] regionBase;
        reset_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held with an M0 read in flight on the bus.
        applyStimulus(1, 0, 8'h04, 0, 32'h0, 8'h00, 0, 0, 32'hCAFE_0001, 32'hBEEF_0002);
        stepCycle("T1rst");
        reset_n = 1'b1;
        stepCycle("T1rel");
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 32'hCAFE_0003, 32'hBEEF_0004);
        stepCycle("T1ret");

        applyStimulus(1, 0, 8'h10, 1, 32'hA5A5_0001, 8'h00, 0, 0, 32'h1111_1111, 32'h2222_2222);
        stepCycle("T2wr");
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h1111_1111, 32'h2222_2222);
        stepCycle("T2post");

        applyStimulus(0, 1, 8'h00, 0, 0, 8'h24, 0, 32'h0, 32'h0, 32'h1234_5678);
        stepCycle("T3rd");
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0, 32'h1234_5678);
        stepCycle("T3ret");

        // Grant hands over to M1 while M0's read is returning.
        applyStimulus(1, 0, 8'h08, 0, 32'h0, 8'h30, 1, 32'h7777_0000, 32'h0BAD_F00D, 32'h5555_5555);
        stepCycle("T4issue");
        applyStimulus(0, 1, 8'h08, 0, 32'h0, 8'h30, 1, 32'h7777_0000, 32'h0BAD_F00D, 32'h5555_5555);
        stepCycle("T4handover");

        applyStimulus(1, 0, 8'h40, 1, 32'hDEAD_BEEF, 8'h00, 0, 0, 32'h0, 32'h0);
        stepCycle("T5miss");
        applyStimulus(1, 0, 8'h00, 0, 32'h0, 8'h00, 0, 0, 32'h0101_0101, 32'h0);
        stepCycle("T5pulse");
        stepCycle("T5clear");

        applyStimulus(1, 1, 8'h3F, 0, 32'h0, 8'h00, 0, 0, 32'h0, 32'h6666_0006);
        stepCycle("Tboth");
        applyStimulus(0, 0, 8'h24, 1, 32'hFFFF_FFFF, 8'h24, 1, 32'hEEEE_EEEE, 32'h0, 32'h0);
        stepCycle("T6nogrant");
        applyStimulus(0, 1, 8'h00, 0, 0, 8'h3C, 0, 32'h0, 32'h0, 32'h9999_0009);
        stepCycle("T6issue");
        assertReset();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0, 32'h9999_0009);
        stepCycle("T6rstmid");
        reset_n = 1'b1;
        stepCycle("T6after");

        for (int i = 0; i < 400; i++) begin
            regionBase = 32'($urandom_range(0, 3)) * 32;
            ra0 = 8'(regionBase + 32'($urandom_range(0, 31)));
            regionBase = 32'($urandom_range(0, 3)) * 32;
            ra1 = 8'(regionBase + 32'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) ra0 = 8'($urandom);
            applyStimulus(1'($urandom), 1'($urandom), ra0, 1'($urandom), $urandom,
                          ra1, 1'($urandom), $urandom, $urandom, $urandom);
            if ($urandom_range(0, 39) == 0) assertReset();
            else reset_n = 1'b1;
            stepCycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
